// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB vs buffered long-latency result.
// Optional buffer-starvation guard enabled by defining RF_WB_FAIRNESS_EN.
module rf_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pipe_valid,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  output logic            pipe_hold,
  input  logic            lop_issue,
  input  logic [4:0]      lop_rd,
  input  logic            mdu_valid,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            mdu_ready,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  input  logic [4:0]      chk_rd,
  output logic            issue_stall,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  logic            hb_valid_q, hb_valid_d;
  logic [4:0]      hb_rd_q, hb_rd_d;
  logic [XLEN-1:0] hb_data_q, hb_data_d;
  logic [31:0]     sb_q, sb_d;
  logic            grant_pipe, grant_hb, force_hb;

`ifdef RF_WB_FAIRNESS_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_q, wait_d;

  assign force_hb = hb_valid_q & (wait_q == WW'(MAX_WAIT));

  always_comb begin
    wait_d = '0;
    if (hb_valid_q & ~grant_hb) begin
      wait_d = (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`else
  assign force_hb = 1'b0;
`endif

  // Granted buffer write lands this cycle, so its register reads as ready.
  function automatic logic busy(input logic [4:0] r);
    return sb_q[r] & ~(grant_hb & (hb_rd_q == r));
  endfunction

  always_comb begin
    grant_pipe  = ~reset & pipe_valid & ~force_hb;
    grant_hb    = ~reset & hb_valid_q & (~pipe_valid | force_hb);
    pipe_hold   = ~reset & pipe_valid & force_hb;
    mdu_ready   = ~reset & (~hb_valid_q | grant_hb);
    issue_stall = ~reset &
                  (busy(chk_rs1) | busy(chk_rs2) | busy(chk_rd));
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    unique case (1'b1)
      grant_pipe: begin
        rf_wen   = (pipe_rd != 5'd0);
        rf_waddr = pipe_rd;
        rf_wdata = pipe_data;
      end
      grant_hb: begin
        rf_wen   = (hb_rd_q != 5'd0);
        rf_waddr = hb_rd_q;
        rf_wdata = hb_data_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    hb_valid_d = hb_valid_q & ~grant_hb;
    hb_rd_d    = hb_rd_q;
    hb_data_d  = hb_data_q;
    if (mdu_valid & mdu_ready) begin
      hb_valid_d = 1'b1;
      hb_rd_d    = mdu_rd;
      hb_data_d  = mdu_data;
    end
    sb_d = sb_q;
    if (grant_hb) sb_d[hb_rd_q] = 1'b0;
    if (lop_issue & (lop_rd != 5'd0)) sb_d[lop_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hb_valid_q <= 1'b0;
      hb_rd_q    <= '0;
      hb_data_q  <= '0;
      sb_q       <= '0;
    end else begin
      hb_valid_q <= hb_valid_d;
      hb_rd_q    <= hb_rd_d;
      hb_data_q  <= hb_data_d;
      sb_q       <= sb_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios followed by randomized
// traffic against a behavioural model of the write-port arbiter.
module tb_rf_wb_arbiter;
  localparam int XLEN = 32;
  localparam int MAX_WAIT = 4;
`ifdef RF_WB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk, reset;
  logic pipe_valid, pipe_hold;
  logic [4:0] pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic lop_issue;
  logic [4:0] lop_rd;
  logic mdu_valid, mdu_ready;
  logic [4:0] mdu_rd;
  logic [XLEN-1:0] mdu_data;
  logic [4:0] chk_rs1, chk_rs2, chk_rd;
  logic issue_stall, rf_wen;
  logic [4:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd),
    .pipe_data(pipe_data), .pipe_hold(pipe_hold),
    .lop_issue(lop_issue), .lop_rd(lop_rd),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd),
    .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .issue_stall(issue_stall), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: one-slot buffer, set of pending registers, wait count.
  bit m_bv;
  logic [4:0] m_brd;
  logic [31:0] m_bdata;
  bit [31:0] m_pend;
  int m_wait;
  bit e_bg, e_pg, e_force, e_wen, e_ready, e_stall, e_hold;
  logic [4:0] e_addr;
  logic [31:0] e_data;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy(input logic [4:0] r);
    return (r != 0) && m_pend[r] && !(e_bg && m_brd == r);
  endfunction

  task automatic model_eval();
    e_force = FAIR && m_bv && (m_wait == MAX_WAIT);
    e_pg = pipe_valid && !e_force;
    e_bg = m_bv && (!pipe_valid || e_force);
    e_addr = 0;
    e_data = 0;
    if (e_pg) begin
      e_addr = pipe_rd;
      e_data = pipe_data;
    end else if (e_bg) begin
      e_addr = m_brd;
      e_data = m_bdata;
    end
    e_wen = (e_pg || e_bg) && (e_addr != 0);
    e_ready = !m_bv || e_bg;
    e_hold = e_force && pipe_valid;
    e_stall = m_busy(chk_rs1) || m_busy(chk_rs2) || m_busy(chk_rd);
    if (reset) begin
      {e_pg, e_bg, e_wen, e_ready, e_stall, e_hold} = '0;
      e_addr = 0;
      e_data = 0;
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_bv = 0;
      m_pend = '0;
      m_wait = 0;
    end else begin
      if (m_bv && !e_bg)
        m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else
        m_wait = 0;
      if (e_bg) begin
        m_bv = 0;
        m_pend[m_brd] = 0;
      end
      if (lop_issue && lop_rd != 0) m_pend[lop_rd] = 1;
      if (mdu_valid && e_ready) begin
        m_bv = 1;
        m_brd = mdu_rd;
        m_bdata = mdu_data;
      end
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
    chk("m_wen", rf_wen, e_wen);
    chk("m_waddr", rf_waddr, e_addr);
    chk("m_wdata", rf_wdata, e_data);
    chk("m_ready", mdu_ready, e_ready);
    chk("m_stall", issue_stall, e_stall);
    chk("m_hold", pipe_hold, e_hold);
    if (lop_issue && !reset) chk("lop_while_stall", issue_stall, 0);
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
    lop_issue = 0; lop_rd = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
  endtask

  bit held;

  initial begin
    idle();
    reset = 1;
    m_bv = 0; m_brd = 0; m_bdata = 0; m_pend = '0; m_wait = 0;
    @(negedge clk);
    // Reset state
    pipe_valid = 1; pipe_rd = 2; mdu_valid = 1; chk_rs1 = 2;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("rst_wen", rf_wen, 0);
      chk("rst_ready", mdu_ready, 0);
      chk("rst_hold", pipe_hold, 0);
      chk("rst_stall", issue_stall, 0);
      adv();
    end
    idle();
    reset = 0;
    settle();
    chk("post_rst_ready", mdu_ready, 1);
    chk("post_rst_wen", rf_wen, 0);
    adv();

    // 1: pipeline-only write
    pipe_valid = 1; pipe_rd = 5; pipe_data = 32'hA5;
    settle();
    chk("t1_wen", rf_wen, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'hA5);
    adv();
    idle();

    // 2: scoreboard set, hazard, writeback clears
    lop_issue = 1; lop_rd = 7;
    settle();
    chk("t2_nostall", issue_stall, 0);
    adv();
    idle();
    chk_rs1 = 7; mdu_valid = 1; mdu_rd = 7; mdu_data = 32'h1234;
    settle();
    chk("t2_stall", issue_stall, 1);
    chk("t2_ready", mdu_ready, 1);
    adv();
    mdu_valid = 0;
    settle();
    chk("t2_wen", rf_wen, 1);
    chk("t2_waddr", rf_waddr, 7);
    chk("t2_wdata", rf_wdata, 32'h1234);
    chk("t2_wt_stall", issue_stall, 0);
    adv();
    settle();
    chk("t2_clear", issue_stall, 0);
    adv();
    idle();

    // 3: pipeline beats the buffer
    mdu_valid = 1; mdu_rd = 3; mdu_data = 32'h33;
    settle();
    adv();
    idle();
    pipe_valid = 1; pipe_rd = 4; pipe_data = 32'h44;
    settle();
    chk("t3_waddr_p", rf_waddr, 4);
    chk("t3_ready_p", mdu_ready, 0);
    adv();
    idle();
    settle();
    chk("t3_wen_b", rf_wen, 1);
    chk("t3_waddr_b", rf_waddr, 3);
    chk("t3_wdata_b", rf_wdata, 32'h33);
    chk("t3_ready_b", mdu_ready, 1);
    adv();

    // 4: x0 never written nor tracked
    pipe_valid = 1; pipe_rd = 0; pipe_data = 32'hFF;
    mdu_valid = 1; mdu_rd = 0; mdu_data = 32'h77;
    lop_issue = 1; lop_rd = 0;
    settle();
    chk("t4_wen_p0", rf_wen, 0);
    adv();
    idle();
    settle();
    chk("t4_wen_b0", rf_wen, 0);
    chk("t4_stall", issue_stall, 0);
    adv();
    pipe_valid = 1; pipe_rd = 1; pipe_data = 32'h1;
    settle();
    chk("t4_drained", mdu_ready, 1);
    chk("t4_waddr", rf_waddr, 1);
    adv();
    idle();

    // 5: continuous pipeline traffic against a full buffer
    mdu_valid = 1; mdu_rd = 10; mdu_data = 32'hBB;
    settle();
    adv();
    idle();
    pipe_valid = 1; pipe_rd = 11; pipe_data = 32'hCC;
    for (int i = 1; i <= 8; i++) begin
      settle();
      chk("t5_hold", pipe_hold, (FAIR && i == 5) ? 1 : 0);
      chk("t5_waddr", rf_waddr, (FAIR && i == 5) ? 10 : 11);
      chk("t5_ready", mdu_ready, (FAIR && i >= 5) ? 1 : 0);
      adv();
    end
    idle();
    settle();
    chk("t5_tail_wen", rf_wen, FAIR ? 0 : 1);
    chk("t5_tail_addr", rf_waddr, FAIR ? 0 : 10);
    adv();

    // 6: reset discards buffer and scoreboard
    lop_issue = 1; lop_rd = 9;
    mdu_valid = 1; mdu_rd = 12; mdu_data = 32'h5;
    settle();
    adv();
    idle();
    chk_rs1 = 9;
    settle();
    chk("t6_pre_stall", issue_stall, 1);
    reset = 1;
    settle();
    chk("t6_rst_wen", rf_wen, 0);
    chk("t6_rst_ready", mdu_ready, 0);
    adv();
    reset = 0;
    settle();
    chk("t6_wen", rf_wen, 0);
    chk("t6_ready", mdu_ready, 1);
    chk("t6_stall", issue_stall, 0);
    adv();
    idle();

    // Randomized legal traffic
    held = 0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom % 300) == 0;
      if (!held) begin
        pipe_valid = $urandom % 2;
        pipe_rd = 5'($urandom);
        pipe_data = $urandom;
        if (m_pend[pipe_rd]) pipe_valid = 0;
      end
      mdu_valid = $urandom % 2;
      mdu_rd = 5'($urandom);
      mdu_data = $urandom;
      chk_rs1 = 5'($urandom);
      chk_rs2 = 5'($urandom);
      chk_rd = 5'($urandom);
      lop_rd = chk_rd;
      lop_issue = ($urandom % 3) == 0;
      if (pipe_valid && lop_rd == pipe_rd) lop_issue = 0;
      model_eval();
      if (e_stall) lop_issue = 0;
      settle();
      held = e_hold;
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
